// File: rtl/uart_baud_gen_frac_pkg.sv
// Shared constants for the UART baud generator and the RX/TX blocks that reuse it.
package uart_baud_gen_frac_pkg;

    // Default geometry: 50 MHz clock, 115200 baud, 16x oversampling.
    localparam int PKG_DIV_W      = 16;
    localparam int PKG_FRAC_W     = 4;
    localparam int PKG_OVERSAMPLE = 16;
    localparam int PKG_DEF_INT    = 27;
    localparam int PKG_DEF_FRAC   = 2;

    // Index width for an oversample position, never narrower than one bit.
    function automatic int idx_width(input int oversample);
        return (oversample > 1) ? $clog2(oversample) : 1;
    endfunction

    // What the counter does on a given edge, in priority order below reset.
    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,  // disabled: park at start of period
        MODE_RESYNC = 2'd1,  // restart phase, suppress ticks
        MODE_COUNT  = 2'd2   // normal down-count
    } mode_e;

endpackage

// File: rtl/uart_baud_gen_frac_if.sv
// Control and tick bundle between the baud generator and its UART user.
interface uart_baud_gen_frac_if
    import uart_baud_gen_frac_pkg::*;
#(
    parameter int DIV_W      = PKG_DIV_W,
    parameter int FRAC_W     = PKG_FRAC_W,
    parameter int OVERSAMPLE = PKG_OVERSAMPLE
);
    localparam int IDX_W = idx_width(OVERSAMPLE);

    logic              enable;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              div_load;
    logic              resync;
    logic              os_tick;
    logic              bit_tick;
    logic [IDX_W-1:0]  os_idx;
    logic              div_pending;

    // Controller side: drives configuration, consumes ticks.
    modport master (
        output enable, div_int, div_frac, div_load, resync,
        input  os_tick, bit_tick, os_idx, div_pending
    );

    // Generator side.
    modport slave (
        input  enable, div_int, div_frac, div_load, resync,
        output os_tick, bit_tick, os_idx, div_pending
    );

endinterface

// File: rtl/uart_baud_gen_frac_acc.sv
// Fractional phase accumulator: adds the fraction once per period and reports
// the carry that stretches the following period by one clock.
module uart_baud_gen_frac_acc #(
    parameter int FRAC_W = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              add_i,
    input  logic [FRAC_W-1:0] frac_i,
    output logic              carry_o
);

    logic [FRAC_W-1:0] acc_q;
    logic [FRAC_W:0]   sum;

    // Carry is combinational so the reload value can use it on the same edge.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, frac_i};
        carry_o = sum[FRAC_W];
    end

    // Accumulator register; clear wins over add.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            acc_q <= '0;
        end else if (add_i) begin
            acc_q <= sum[FRAC_W-1:0];
        end
    end

endmodule

// File: rtl/uart_baud_gen_frac.sv
// Fractional-divisor UART baud generator producing oversample and bit ticks.
// Average oversample period is div_int + div_frac / 2^FRAC_W clocks.
module uart_baud_gen_frac
    import uart_baud_gen_frac_pkg::*;
#(
    parameter int DIV_W      = PKG_DIV_W,
    parameter int FRAC_W     = PKG_FRAC_W,
    parameter int OVERSAMPLE = PKG_OVERSAMPLE,
    parameter int DEF_INT    = PKG_DEF_INT,
    parameter int DEF_FRAC   = PKG_DEF_FRAC
)(
    input  logic               clk,
    input  logic               reset,
    uart_baud_gen_frac_if.slave bus
);

    localparam int IDX_W = idx_width(OVERSAMPLE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OVERSAMPLE - 1);
    localparam logic [DIV_W-1:0] RST_INT  = DIV_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DEF_FRAC);

    // Counter reload for a divisor; zero behaves like one.
    function automatic logic [DIV_W-1:0] reload_of(input logic [DIV_W-1:0] d);
        return (d == '0) ? '0 : d - 1'b1;
    endfunction

    logic [DIV_W-1:0]  act_int_q,  act_int_d;
    logic [FRAC_W-1:0] act_frac_q, act_frac_d;
    logic [DIV_W-1:0]  shd_int_q,  shd_int_d;
    logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
    logic              pend_q,     pend_d;
    logic [DIV_W-1:0]  cnt_q,      cnt_d;
    logic [IDX_W-1:0]  idx_q,      idx_d;      // index the next tick will carry
    logic [IDX_W-1:0]  os_idx_q,   os_idx_d;   // index of the last tick
    logic              os_tick_q,  os_tick_d;
    logic              bit_tick_q, bit_tick_d;

    logic              acc_clear;
    logic              acc_add;
    logic [FRAC_W-1:0] acc_frac;
    logic              acc_carry;
    mode_e             mode;

    uart_baud_gen_frac_acc #(.FRAC_W(FRAC_W)) u_acc (
        .clk     (clk),
        .reset   (reset),
        .clear_i (acc_clear),
        .add_i   (acc_add),
        .frac_i  (acc_frac),
        .carry_o (acc_carry)
    );

    // Next-state logic: hold, resync or count, plus shadow/active divisor hand-over.
    always_comb begin
        act_int_d  = act_int_q;
        act_frac_d = act_frac_q;
        shd_int_d  = shd_int_q;
        shd_frac_d = shd_frac_q;
        pend_d     = pend_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        os_idx_d   = os_idx_q;
        os_tick_d  = 1'b0;
        bit_tick_d = 1'b0;
        acc_clear  = 1'b0;
        acc_add    = 1'b0;
        acc_frac   = act_frac_q;

        if (!bus.enable) begin
            mode = MODE_HOLD;
        end else if (bus.resync) begin
            mode = MODE_RESYNC;
        end else begin
            mode = MODE_COUNT;
        end

        case (mode)
            MODE_HOLD: begin
                // Nothing is running, so a new divisor can take effect at once.
                if (bus.div_load) begin
                    act_int_d  = bus.div_int;
                    act_frac_d = bus.div_frac;
                    shd_int_d  = bus.div_int;
                    shd_frac_d = bus.div_frac;
                    pend_d     = 1'b0;
                end
                cnt_d     = reload_of(act_int_d);
                acc_clear = 1'b1;
                idx_d     = '0;
                os_idx_d  = '0;
            end
            MODE_RESYNC: begin
                cnt_d     = reload_of(act_int_q);
                acc_clear = 1'b1;
                idx_d     = '0;
                os_idx_d  = '0;
                if (bus.div_load) begin
                    shd_int_d  = bus.div_int;
                    shd_frac_d = bus.div_frac;
                    pend_d     = 1'b1;
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    // Period boundary: promote a pending shadow, then start the
                    // next period with it, stretched by one clock on carry.
                    if (pend_q) begin
                        act_int_d  = shd_int_q;
                        act_frac_d = shd_frac_q;
                    end
                    pend_d     = 1'b0;
                    acc_add    = 1'b1;
                    acc_frac   = act_frac_d;
                    cnt_d      = reload_of(act_int_d) + {{(DIV_W-1){1'b0}}, acc_carry};
                    os_tick_d  = 1'b1;
                    bit_tick_d = (idx_q == LAST_IDX);
                    os_idx_d   = idx_q;
                    idx_d      = idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
                // A load on the boundary lands in the shadow after the old shadow moved out.
                if (bus.div_load) begin
                    shd_int_d  = bus.div_int;
                    shd_frac_d = bus.div_frac;
                    pend_d     = 1'b1;
                end
            end
        endcase
    end

    // State and output registers; reset discards any pending shadow.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_int_q  <= RST_INT;
            act_frac_q <= RST_FRAC;
            shd_int_q  <= RST_INT;
            shd_frac_q <= RST_FRAC;
            pend_q     <= 1'b0;
            cnt_q      <= reload_of(RST_INT);
            idx_q      <= '0;
            os_idx_q   <= '0;
            os_tick_q  <= 1'b0;
            bit_tick_q <= 1'b0;
        end else begin
            act_int_q  <= act_int_d;
            act_frac_q <= act_frac_d;
            shd_int_q  <= shd_int_d;
            shd_frac_q <= shd_frac_d;
            pend_q     <= pend_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            os_idx_q   <= os_idx_d;
            os_tick_q  <= os_tick_d;
            bit_tick_q <= bit_tick_d;
        end
    end

    assign bus.os_tick     = os_tick_q;
    assign bus.bit_tick    = bit_tick_q;
    assign bus.os_idx      = os_idx_q;
    assign bus.div_pending = pend_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Directed bench: stimulus pushes expected ticks (edge number, index, bit flag)
// into a queue; a negedge monitor pops one entry per observed os_tick.
module tb_uart_baud_gen_frac;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;

    typedef struct {
        int cyc;
        int idx;
        bit bt;
    } exp_t;
    exp_t exp_q[$];

    uart_baud_gen_frac_if bus ();

    uart_baud_gen_frac dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Edge counter: value seen at a negedge is the number of rising edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act == req) passed++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    endtask

    task automatic push(input int c, input int i);
        exp_q.push_back('{cyc: c, idx: i, bt: (i == 15)});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Park the generator, load a divisor while idle, then re-enable.
    task automatic reconfig(input int di, input int df);
        bus.enable   = 1'b0;
        bus.div_load = 1'b1;
        bus.div_int  = di[15:0];
        bus.div_frac = df[3:0];
        @(negedge clk);
        bus.div_load = 1'b0;
        check("pending_after_idle_load", int'(bus.div_pending), 0);
        bus.enable = 1'b1;
    endtask

    // Monitor: every os_tick must match the head of the expectation queue.
    always @(negedge clk) begin
        exp_t e;
        if (bus.os_tick) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL unexpected_tick: os_tick at cycle %0d idx %0d, none expected",
                         cyc, bus.os_idx);
            end else begin
                e = exp_q.pop_front();
                if (cyc == e.cyc && int'(bus.os_idx) == e.idx && bus.bit_tick == e.bt) begin
                    passed++;
                    $display("tick cycle %0d idx %0d bit %0d", cyc, bus.os_idx, bus.bit_tick);
                end else begin
                    $display("FAIL tick: got cycle %0d idx %0d bit %0d, expected cycle %0d idx %0d bit %0d",
                             cyc, bus.os_idx, bus.bit_tick, e.cyc, e.idx, e.bt);
                end
            end
        end else if (bus.bit_tick) begin
            checks++;
            $display("FAIL bit_without_os: bit_tick at cycle %0d without os_tick", cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;
        int t;
        int last;

        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.div_load = 1'b0;
        bus.resync   = 1'b0;
        bus.div_int  = '0;
        bus.div_frac = '0;
        repeat (3) @(negedge clk);

        check("rst_os_tick",  int'(bus.os_tick), 0);
        check("rst_bit_tick", int'(bus.bit_tick), 0);
        check("rst_os_idx",   int'(bus.os_idx), 0);
        check("rst_pending",  int'(bus.div_pending), 0);

        // Defaults 27 + 2/16: 16 intervals = 27 x14 + 28 x2 (carry after ticks 8 and 16).
        reset      = 1'b0;
        bus.enable = 1'b1;
        e0 = cyc;
        t  = e0 + 27;
        last = t;
        for (int k = 0; k < 17; k++) begin
            push(t, k % 16);
            last = t;
            t += (k == 7 || k == 15) ? 28 : 27;
        end
        wait_until(last);

        // Idle load of 4 + 8/16: ticks at 4, 8, 13, 17, 22.
        reconfig(4, 8);
        e0 = cyc;
        push(e0 + 4, 0);
        push(e0 + 8, 1);
        push(e0 + 13, 2);
        push(e0 + 17, 3);
        push(e0 + 22, 4);
        wait_until(e0 + 22);
        check("pending_idle_load_run", int'(bus.div_pending), 0);

        // Running at 4, load 6 two clocks after a tick; switch at the next boundary.
        reconfig(4, 0);
        e0 = cyc;
        push(e0 + 4, 0);
        push(e0 + 8, 1);
        push(e0 + 14, 2);
        push(e0 + 20, 3);
        wait_until(e0 + 5);
        bus.div_load = 1'b1;
        bus.div_int  = 16'd6;
        @(negedge clk);
        bus.div_load = 1'b0;
        check("pending_set", int'(bus.div_pending), 1);
        @(negedge clk);
        check("pending_held", int'(bus.div_pending), 1);
        @(negedge clk);
        check("pending_cleared_on_tick", int'(bus.div_pending), 0);

        // Resync one clock before the tick due at e0+26: next tick 6 clocks after.
        wait_until(e0 + 24);
        bus.resync = 1'b1;
        @(negedge clk);
        bus.resync = 1'b0;
        for (int k = 0; k < 16; k++) push(e0 + 31 + 6 * k, k);
        wait_until(e0 + 31 + 6 * 15);

        // Divisor 0 and 1 both tick every enabled cycle.
        for (int di = 0; di < 2; di++) begin
            reconfig(di, 0);
            e0 = cyc;
            for (int k = 0; k < 20; k++) push(e0 + 1 + k, k % 16);
            wait_until(e0 + 20);
        end

        // Reset mid-period with a pending shadow: defaults come back, shadow dropped.
        reconfig(4, 0);
        e0 = cyc;
        push(e0 + 4, 0);
        wait_until(e0 + 4);
        bus.div_load = 1'b1;
        bus.div_int  = 16'd9;
        @(negedge clk);
        bus.div_load = 1'b0;
        check("pending_before_reset", int'(bus.div_pending), 1);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_os_tick",  int'(bus.os_tick), 0);
        check("midrst_bit_tick", int'(bus.bit_tick), 0);
        check("midrst_os_idx",   int'(bus.os_idx), 0);
        check("midrst_pending",  int'(bus.div_pending), 0);
        reset = 1'b0;
        e1 = cyc;
        push(e1 + 27, 0);
        push(e1 + 54, 1);
        wait_until(e1 + 60);

        check("all_expected_ticks_seen", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
